// File: rtl/arith_sched_pkg.sv
// Shared definitions for the arithmetic unit scheduler: FSM states,
// the packed multiplier latency and the operand mode encodings.
package arith_sched_pkg;

    typedef enum logic {
        ISSUE = 1'b0,
        DRAIN = 1'b1
    } schedState_e;

    localparam int AU_LATENCY = 4;

    localparam logic MODE_INT8 = 1'b0;
    localparam logic MODE_INT4 = 1'b1;

endpackage

// File: rtl/arith_sched_tag_pipe.sv
// Shift register carrying {valid, id} alongside the arithmetic unit so each
// product can be routed back to the requester that issued it.
module arith_sched_tag_pipe
    import arith_sched_pkg::*;
#(
    parameter int DEPTH = AU_LATENCY + 1
) (
    input  logic clk_i,
    input  logic clear_ni,
    input  logic valid_i,
    input  logic id_i,
    output logic valid_o,
    output logic id_o
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] id_q;

    // Advance one stage per cycle; a clear drops every tag still in flight.
    always_ff @(posedge clk_i) begin
        if (!clear_ni) begin
            valid_q <= '0;
            id_q    <= '0;
        end else begin
            valid_q <= {valid_q[DEPTH-2:0], valid_i};
            id_q    <= {id_q[DEPTH-2:0], id_i};
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign id_o    = id_q[DEPTH-1];

endmodule

// File: rtl/arithmetic_unit_scheduler.sv
// Round-robin scheduler sharing one packed DSP multiplier between two
// requesters. The unit's output format follows its live mode input, so all
// in-flight work is drained before the mode changes.
// Optional build macro ARITH_SCHED_PERF_EN adds saturating issue/drain counters.
module arithmetic_unit_scheduler
    import arith_sched_pkg::*;
#(
    parameter int LATENCY = AU_LATENCY
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [15:0] req0_x_i,
    input  logic [7:0]  req0_y_i,
    input  logic        req0_mode_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [15:0] req1_x_i,
    input  logic [7:0]  req1_y_i,
    input  logic        req1_mode_i,
    output logic [15:0] au_x_o,
    output logic [7:0]  au_y_o,
    output logic        au_mode_o,
    output logic        au_reset_o,
    input  logic [31:0] au_p_i,
`ifdef ARITH_SCHED_PERF_EN
    output logic [31:0] perf_issue_cnt_o,
    output logic [31:0] perf_drain_cnt_o,
`endif
    output logic        res_valid_o,
    output logic        res_id_o,
    output logic [31:0] res_p_o
);

    localparam int CNT_W = $clog2(LATENCY + 2);

    schedState_e      state_q;
    logic             rr_q;
    logic             auMode_q;
    logic             pendMode_q;
    logic [15:0]      auX_q;
    logic [7:0]       auY_q;
    logic [15:0]      auX_d;
    logic [7:0]       auY_d;
    logic [CNT_W-1:0] inFlight_q;
    logic [CNT_W-1:0] inFlight_d;

    logic             winnerValid;
    logic             winnerId;
    logic             winnerMode;
    logic [15:0]      winnerX;
    logic [7:0]       winnerY;
    logic             issueOk;
    logic             fire;
    logic             tagValid;
    logic             tagId;

    // Pick the winner (round-robin only on contention) and grant it when its mode matches the unit.
    always_comb begin
        winnerValid = req0_valid_i | req1_valid_i;
        if (req0_valid_i && req1_valid_i) begin
            winnerId = rr_q;
        end else begin
            winnerId = req1_valid_i;
        end
        winnerMode = winnerId ? req1_mode_i : req0_mode_i;
        winnerX    = winnerId ? req1_x_i    : req0_x_i;
        winnerY    = winnerId ? req1_y_i    : req0_y_i;
        issueOk    = reset_i && (state_q == ISSUE) && winnerValid && (winnerMode == auMode_q);
        req0_ready_o = issueOk && !winnerId;
        req1_ready_o = issueOk && winnerId;
        fire = (req0_valid_i && req0_ready_o) || (req1_valid_i && req1_ready_o);
    end

    // Issue/drain control: a mode mismatch parks the winner until the pipe is empty.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q    <= ISSUE;
            rr_q       <= 1'b0;
            auMode_q   <= MODE_INT8;
            pendMode_q <= MODE_INT8;
        end else begin
            case (state_q)
                ISSUE: begin
                    if (fire) begin
                        rr_q <= ~winnerId;
                    end else if (winnerValid && (winnerMode != auMode_q)) begin
                        pendMode_q <= winnerMode;
                        state_q    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (inFlight_q == '0) begin
                        auMode_q <= pendMode_q;
                        state_q  <= ISSUE;
                    end
                end
                default: state_q <= ISSUE;
            endcase
        end
    end

    // Next operand values and in-flight count; idle cycles feed zeros into the unit.
    always_comb begin
        auX_d = fire ? winnerX : 16'h0000;
        auY_d = fire ? winnerY : 8'h00;
        inFlight_d = inFlight_q;
        if (fire && !tagValid) begin
            inFlight_d = inFlight_q + CNT_W'(1);
        end else if (!fire && tagValid) begin
            inFlight_d = inFlight_q - CNT_W'(1);
        end
    end

    // Operand register and in-flight counter.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            auX_q      <= '0;
            auY_q      <= '0;
            inFlight_q <= '0;
        end else begin
            auX_q      <= auX_d;
            auY_q      <= auY_d;
            inFlight_q <= inFlight_d;
        end
    end

    arith_sched_tag_pipe #(
        .DEPTH(LATENCY + 1)
    ) u_tagPipe (
        .clk_i   (clk_i),
        .clear_ni(reset_i),
        .valid_i (fire),
        .id_i    (winnerId),
        .valid_o (tagValid),
        .id_o    (tagId)
    );

    assign au_x_o      = auX_q;
    assign au_y_o      = auY_q;
    assign au_mode_o   = auMode_q;
    assign au_reset_o  = ~reset_i;
    assign res_valid_o = tagValid;
    assign res_id_o    = tagId;
    assign res_p_o     = au_p_i;

`ifdef ARITH_SCHED_PERF_EN
    logic [31:0] perfIssue_q;
    logic [31:0] perfDrain_q;

    // Saturating counts of issued operations and cycles lost to draining.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            perfIssue_q <= '0;
            perfDrain_q <= '0;
        end else begin
            if (fire && (perfIssue_q != 32'hFFFF_FFFF)) begin
                perfIssue_q <= perfIssue_q + 32'd1;
            end
            if ((state_q == DRAIN) && (perfDrain_q != 32'hFFFF_FFFF)) begin
                perfDrain_q <= perfDrain_q + 32'd1;
            end
        end
    end

    assign perf_issue_cnt_o = perfIssue_q;
    assign perf_drain_cnt_o = perfDrain_q;
`endif

endmodule
